// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and index constants for the register file.
// Holds the default widths, the hard-wired zero and stack-pointer register
// indices, the stack-pointer reset value, and the saturating write-counter
// increment helper.
package reg_file_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_SP   = 29;

  localparam logic [31:0] SP_INIT_DEF = 32'h7FFF_EFFC;

  localparam int unsigned CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port of the register file.
// Ports:
//   addr_i     - register index to read
//   regs_i     - flattened register storage (index-major)
//   byp_en_i   - a write is committing this cycle and may be forwarded
//   byp_addr_i - index of that write
//   byp_data_i - data of that write
//   data_o     - read data; index 0 always reads zero
module regfile_rd_port
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0]                      addr_i,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]     regs_i,
  input  logic                                   byp_en_i,
  input  logic [ADDR_W-1:0]                      byp_addr_i,
  input  logic [DATA_W-1:0]                      byp_data_i,
  output logic [DATA_W-1:0]                      data_o
);

  always_comb begin
    data_o = regs_i[addr_i];
    if (addr_i == ADDR_W'(REG_ZERO)) begin
      data_o = '0;
    end else if (byp_en_i && (byp_addr_i == addr_i)) begin
      data_o = byp_data_i;
    end
  end

endmodule

// File: rtl/reg_file.sv
// reg_file: 2**ADDR_W x DATA_W register file, two combinational read ports,
// one synchronous write port, and a saturating count of committed writes.
// Register 0 reads as zero and ignores writes; register 29 ($sp) resets to
// SP_INIT. Reset is synchronous, active-low, and beats a same-edge write.
// Optional feature macro: REGFILE_BYPASS_EN forwards a committing write to a
// read port addressing the same (non-zero) index in the same cycle.
// Ports:
//   clk, rst_n        - clock (rising edge) and synchronous active-low reset
//   rs_addr, rs_data  - read port A index / data
//   rt_addr, rt_data  - read port B index / data
//   wr_en, wr_addr,
//   wr_data           - write enable, index, data
//   wr_cnt            - saturating count of committed writes
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned       DATA_W  = DATA_W_DEF,
  parameter int unsigned       ADDR_W  = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(SP_INIT_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam int unsigned NREGS = 1 << ADDR_W;

  logic [NREGS-1:0][DATA_W-1:0] regs_q;
  logic [CNT_W-1:0]             wr_cnt_q, wr_cnt_d;
  logic                         wr_commit;
  logic                         byp_en;

  assign wr_commit = wr_en && (wr_addr != ADDR_W'(REG_ZERO));

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (wr_commit) begin
      wr_cnt_d = sat_inc(wr_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == REG_SP) ? SP_INIT : '0;
      end
      wr_cnt_q <= '0;
    end else begin
      if (wr_commit) begin
        regs_q[wr_addr] <= wr_data;
      end
      wr_cnt_q <= wr_cnt_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is withheld during reset because the write will be dropped.
  assign byp_en = rst_n && wr_commit;
`else
  assign byp_en = 1'b0;
`endif

  regfile_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_rs (
    .addr_i     (rs_addr),
    .regs_i     (regs_q),
    .byp_en_i   (byp_en),
    .byp_addr_i (wr_addr),
    .byp_data_i (wr_data),
    .data_o     (rs_data)
  );

  regfile_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_rt (
    .addr_i     (rt_addr),
    .regs_i     (regs_q),
    .byp_en_i   (byp_en),
    .byp_addr_i (wr_addr),
    .byp_data_i (wr_data),
    .data_o     (rt_data)
  );

  assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file.
module tb_reg_file;

  localparam logic [31:0] SP_VAL = 32'h7FFF_EFFC;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs_addr, rt_addr, wr_addr;
  logic [31:0] rs_data, rt_data, wr_data;
  logic        wr_en;
  logic [15:0] wr_cnt;

  int unsigned npass = 0;
  int unsigned ntot  = 0;

  reg_file #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .SP_INIT (32'h7FFF_EFFC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_cnt  (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_rs, exp_rt;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rs_addr = '0;
    rt_addr = '0;

    // Reset for one edge
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      exp_rs  = (i == 29) ? SP_VAL : 32'h0;
      exp_rt  = ((31 - i) == 29) ? SP_VAL : 32'h0;
      #1;
      check($sformatf("reset_rs[%0d]", i), rs_data, exp_rs);
      check($sformatf("reset_rt[%0d]", 31 - i), rt_data, exp_rt);
    end
    check("reset_cnt", {16'h0, wr_cnt}, 32'h0);

    // Write then read on both ports
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hDEAD_BEEF;
    step();
    wr_en = 1'b0; rs_addr = 5'd8; rt_addr = 5'd8;
    #1;
    check("wr8_rs", rs_data, 32'hDEAD_BEEF);
    check("wr8_rt", rt_data, 32'hDEAD_BEEF);
    check("wr8_cnt", {16'h0, wr_cnt}, 32'd1);

    // Write to register 0 is discarded
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678;
    step();
    wr_en = 1'b0; rs_addr = 5'd0; rt_addr = 5'd0;
    #1;
    check("zero_rs", rs_data, 32'h0);
    check("zero_rt", rt_data, 32'h0);
    check("zero_cnt", {16'h0, wr_cnt}, 32'd1);

    // wr_en low changes nothing
    wr_en = 1'b0; wr_addr = 5'd8; wr_data = 32'h0BAD_F00D;
    step();
    rs_addr = 5'd8;
    #1;
    check("hold_rs", rs_data, 32'hDEAD_BEEF);
    check("hold_cnt", {16'h0, wr_cnt}, 32'd1);

    // Preload index 9 with 1
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1;
    step();
    check("pre9_cnt", {16'h0, wr_cnt}, 32'd2);

    // Same-cycle read of index being written
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5_A5A5;
    rs_addr = 5'd9; rt_addr = 5'd8;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_rs", rs_data, 32'hA5A5_A5A5);
`else
    check("byp_rs", rs_data, 32'h1);
`endif
    check("byp_rt_other", rt_data, 32'hDEAD_BEEF);
    step();
    wr_en = 1'b0;
    #1;
    check("after_byp_rs", rs_data, 32'hA5A5_A5A5);
    check("after_byp_cnt", {16'h0, wr_cnt}, 32'd3);

    // Forwarding never applies to index 0
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_0055;
    rs_addr = 5'd0; rt_addr = 5'd0;
    #1;
    check("byp0_rs", rs_data, 32'h0);
    check("byp0_rt", rt_data, 32'h0);
    step();
    wr_en = 1'b0;
    check("byp0_cnt", {16'h0, wr_cnt}, 32'd3);

    // Highest index, independent ports
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h8000_0001;
    step();
    wr_en = 1'b0; rs_addr = 5'd31; rt_addr = 5'd9;
    #1;
    check("r31_rs", rs_data, 32'h8000_0001);
    check("r31_rt", rt_data, 32'hA5A5_A5A5);
    check("r31_cnt", {16'h0, wr_cnt}, 32'd4);

    // Reset together with a write: reads stay ungated, forwarding suppressed
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd29; wr_data = 32'hFFFF_FFFF;
    rs_addr = 5'd29; rt_addr = 5'd8;
    #1;
    check("rstw_rs_pre", rs_data, SP_VAL);
    check("rstw_rt_pre", rt_data, 32'hDEAD_BEEF);
    step();
    rst_n = 1'b1; wr_en = 1'b0;
    #1;
    check("rstw_rs", rs_data, SP_VAL);
    check("rstw_rt", rt_data, 32'h0);
    check("rstw_cnt", {16'h0, wr_cnt}, 32'd0);
    rs_addr = 5'd31;
    #1;
    check("rstw_r31", rs_data, 32'h0);

    // Saturation of the write counter
    force dut.wr_cnt_q = 16'hFFFE;
    #1;
    release dut.wr_cnt_q;
    #1;
    check("sat_preload", {16'h0, wr_cnt}, 32'h0000_FFFE);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h11;
    step();
    check("sat_1", {16'h0, wr_cnt}, 32'h0000_FFFF);
    wr_data = 32'h22;
    step();
    check("sat_2", {16'h0, wr_cnt}, 32'h0000_FFFF);
    wr_data = 32'h33;
    step();
    check("sat_3", {16'h0, wr_cnt}, 32'h0000_FFFF);
    wr_en = 1'b0; rs_addr = 5'd5;
    step();
    check("sat_r5", rs_data, 32'h33);
    check("sat_hold", {16'h0, wr_cnt}, 32'h0000_FFFF);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the register and data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the register index width, giving 2**ADDR_W registers.
REQ-003 The block SHALL have parameter SP_INIT, default 32'h7FFF_EFFC, meaning the reset value of register 29 ($sp).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, the reset; reset is synchronous and active-low.
REQ-006 The block SHALL have port rs_addr, input, ADDR_W, the read port A index.
REQ-007 The block SHALL have port rt_addr, input, ADDR_W, the read port B index.
REQ-008 The block SHALL have port rs_data, output, DATA_W, the read port A data.
REQ-009 The block SHALL have port rt_data, output, DATA_W, the read port B data.
REQ-010 The block SHALL have port wr_en, input, 1, the write enable (RegWrite).
REQ-011 The block SHALL have port wr_addr, input, ADDR_W, the write index (the RegDst mux output).
REQ-012 The block SHALL have port wr_data, input, DATA_W, the write data (the MemtoReg 32-bit mux output).
REQ-013 The block SHALL have port wr_cnt, output, 16, a saturating count of committed writes.

Function
REQ-014 Reads SHALL be combinational: rs_data and rt_data reflect the stored registers addressed by rs_addr and rt_addr within the same cycle, with zero-cycle latency.
REQ-015 Register 0 SHALL always read 0; writes to index 0 SHALL be discarded and SHALL NOT increment wr_cnt.
REQ-016 When rst_n=1, wr_en=1, and wr_addr!=0 at a rising clk edge, the block SHALL set reg[wr_addr] to wr_data; the written value is visible on the read ports from the next cycle.
REQ-017 When wr_en=0, no register SHALL change.
REQ-018 Both read ports SHALL be independent; identical addresses on both ports SHALL return identical data.
REQ-019 wr_cnt SHALL increment by 1 on each committed write (per REQ-016) and SHALL saturate at 16'hFFFF (no wrap-around).
REQ-020 Writes SHALL be full-width DATA_W bits with no sign or zero manipulation.

Reset
REQ-021 When rst_n=0 at a rising clk edge, the block SHALL clear all registers to 0, except that it SHALL load reg[29] with SP_INIT and clear wr_cnt to 0.
REQ-022 Reset SHALL take priority over a simultaneous write; the write SHALL be lost.
REQ-023 While rst_n=0, read ports SHALL continue to return the stored contents combinationally; the block SHALL NOT gate them.
REQ-024 Reset asserted mid-sequence SHALL restore the state of REQ-021 in exactly one edge, independent of prior writes.

Configuration
REQ-025 With macro REGFILE_BYPASS_EN defined, the block SHALL forward write data: if wr_en=1, wr_addr!=0, and wr_addr equals a read address, that port SHALL return wr_data in the same cycle.
REQ-026 Without REGFILE_BYPASS_EN, read ports SHALL return the pre-edge stored value during the write cycle.
REQ-027 Bypass SHALL never apply to index 0, and SHALL be suppressed while rst_n=0.

Structure
REQ-028 A shared package SHALL hold DATA_W/ADDR_W defaults, the REG_ZERO=0 and REG_SP=29 index constants, and SP_INIT.
REQ-029 A single sub-module, regfile_rd_port (index, storage, bypass inputs -> data), SHALL be instantiated twice, once for rs and once for rt; the implementation SHALL contain no other hierarchy.

Verification
REQ-030 Reset: hold rst_n=0 for one edge -> every index reads 0, index 29 reads 32'h7FFF_EFFC, and wr_cnt=0.
REQ-031 Write/read: write 32'hDEAD_BEEF to index 8, then read rs=8, rt=8 -> both ports return 32'hDEAD_BEEF; wr_cnt=1.
REQ-032 Zero register: write 32'h1234_5678 to index 0 -> index 0 reads 0 and wr_cnt is unchanged.
REQ-033 Bypass: read rs_addr=9 (holding 32'h1) while writing 32'hA5A5_A5A5 to index 9 -> same-cycle rs_data is 32'hA5A5_A5A5 with REGFILE_BYPASS_EN defined, and 32'h1 without it.
REQ-034 Reset versus write: assert rst_n=0 in the same cycle as writing 32'hFFFF_FFFF to index 29 -> index 29 reads 32'h7FFF_EFFC.
REQ-035 Saturation: preload wr_cnt=16'hFFFE, then perform 3 writes to index 5 -> wr_cnt is 16'hFFFF and stays at 16'hFFFF.
